// File: rtl/aes_pkg.sv
// Shared Rijndael datapath constants and helpers used by the ShiftRows stage
// and by the key-schedule test model.
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 4 * BYTE_W;

    function automatic int state_w(input int nb);
        return WORD_W * nb;
    endfunction

    // Row rotation amount; the 8-column block skips offset 2 in the lower rows.
    function automatic int row_offset(input int nb, input int row);
        int off;
        if (nb == 8 && row >= 2) begin
            off = row + 1;
        end else begin
            off = row;
        end
        return off;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Purely combinational (Inv)ShiftRows byte permutation for an NB-column state.
// Column 0 / row 0 is the most significant byte.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic                   i_inv,
    input  logic [state_w(NB)-1:0] i_state,
    output logic [state_w(NB)-1:0] o_state
);

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < NB; j++) begin : g_col
            localparam int C     = row_offset(NB, i);
            localparam int J_FWD = (j + C) % NB;
            localparam int J_INV = (j - C + NB) % NB;
            localparam int DST   = WORD_W * (NB - 1 - j)     + BYTE_W * (3 - i);
            localparam int S_FWD = WORD_W * (NB - 1 - J_FWD) + BYTE_W * (3 - i);
            localparam int S_INV = WORD_W * (NB - 1 - J_INV) + BYTE_W * (3 - i);

            assign o_state[DST +: BYTE_W] = i_inv ? i_state[S_INV +: BYTE_W]
                                                  : i_state[S_FWD +: BYTE_W];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined (Inv)ShiftRows stage with valid/ready handshakes on both sides;
// the permutation sits in front of the first register, the mode tag rides along.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_valid,
    output logic                   IN_ready,
    input  logic                   IN_inv,
    input  logic [state_w(NB)-1:0] IN_state,
    output logic                   OUT_valid,
    input  logic                   OUT_ready,
    output logic                   OUT_inv,
    output logic [state_w(NB)-1:0] OUT_state
);

    localparam int SW = state_w(NB);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1 or 2");
    end

    logic [SW-1:0]     w_perm;
    logic [STAGES-1:0] w_ready;
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_inv;
    logic [SW-1:0]     w_state [STAGES];

    shift_rows_perm #(
        .NB(NB)
    ) u_perm (
        .i_inv  (IN_inv),
        .i_state(IN_state),
        .o_state(w_perm)
    );

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          r_valid;
        logic          r_inv;
        logic [SW-1:0] r_state;
        logic          w_up_valid;
        logic          w_up_inv;
        logic [SW-1:0] w_up_state;

        if (k == 0) begin : g_head
            assign w_up_valid = IN_valid;
            assign w_up_inv   = IN_inv;
            assign w_up_state = w_perm;
        end else begin : g_body
            assign w_up_valid = w_valid[k-1];
            assign w_up_inv   = w_inv[k-1];
            assign w_up_state = w_state[k-1];
        end

        // Unrolled ready chain: a stage can move if the output drains or any stage from here on has a hole.
        assign w_ready[k] = OUT_ready || !(&w_valid[STAGES-1:k]);

        // Advance on ready; payload loads only on a real transfer so an idle input never disturbs held data.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_valid <= 1'b0;
                r_inv   <= 1'b0;
                r_state <= '0;
            end else if (w_ready[k]) begin
                r_valid <= w_up_valid;
                if (w_up_valid) begin
                    r_inv   <= w_up_inv;
                    r_state <= w_up_state;
                end else begin
                    r_inv   <= r_inv;
                    r_state <= r_state;
                end
            end else begin
                r_valid <= r_valid;
                r_inv   <= r_inv;
                r_state <= r_state;
            end
        end

        assign w_valid[k] = r_valid;
        assign w_inv[k]   = r_inv;
        assign w_state[k] = r_state;
    end

    assign IN_ready  = w_ready[0];
    assign OUT_valid = w_valid[STAGES-1];
    assign OUT_inv   = w_inv[STAGES-1];
    assign OUT_state = w_state[STAGES-1];

endmodule
